mem_arbiter: RTL and testbench

Shares the single memory port between the instruction fetch unit (read-only) and the load/store unit (read/write) of the NPC pipeline. It accepts one request at a time, forwards it to the downstream memory slave, and routes the response back to the owner. Simultaneous requests are resolved round-robin, and a watchdog converts a hung transaction into an error response. It sits between IFU/LSU and the memory model, replacing their private memory paths.

---
 rtl/npc_mem_pkg.sv | 21 ++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_mem_pkg.sv
// Shared types for the IFU/LSU memory port: arbiter states, owner encoding, watchdog sizing.
package npc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        ERR  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    // Watchdog must be able to hold the value TIMEOUT itself.
    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin IFU/LSU arbiter onto one memory slave; 0-cycle grant in IDLE, registered request, combinational response path.
// One transaction in flight; owner rsp_ready backpressures the slave, a watchdog turns a hung response into an error.
module mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                lsu_rsp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_err
);

    localparam int             WD_W   = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    owner_t                last_q,  last_d;
    logic [WD_W-1:0]       wd_q,    wd_d;
    logic [ADDR_W-1:0]     addr_q,  addr_d;
    logic                  wen_q,   wen_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wmask_q, wmask_d;

    logic pick_lsu, pick_ifu, grant_ok, owner_rsp_ready, in_rsp, in_err, ifu_sel;

    // LSU wins when alone, or on a tie when the IFU was granted last.
    assign pick_lsu = lsu_req_valid && (!ifu_req_valid || last_q == OWN_IFU);
    assign pick_ifu = ifu_req_valid && !pick_lsu;
    assign grant_ok = (state_q == IDLE) && !rst;

    assign ifu_req_ready = grant_ok && pick_ifu;
    assign lsu_req_ready = grant_ok && pick_lsu;

    assign owner_rsp_ready = (owner_q == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
    assign in_rsp  = (state_q == RSP);
    assign in_err  = (state_q == ERR);
    assign ifu_sel = (owner_q == OWN_IFU);

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    // IDLE drains stray responses from abandoned or timed-out transactions.
    assign mem_rsp_ready = (state_q == IDLE) || (in_rsp && owner_rsp_ready);

    assign ifu_rsp_valid = ifu_sel && (in_rsp ? mem_rsp_valid : in_err);
    assign ifu_rsp_err   = ifu_sel && (in_rsp ? mem_rsp_err : in_err);
    assign ifu_rsp_data  = (ifu_sel && in_rsp) ? mem_rsp_data : '0;
    assign lsu_rsp_valid = !ifu_sel && (in_rsp ? mem_rsp_valid : in_err);
    assign lsu_rsp_err   = !ifu_sel && (in_rsp ? mem_rsp_err : in_err);
    assign lsu_rsp_data  = (!ifu_sel && in_rsp) ? mem_rsp_data : '0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wd_d    = wd_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            IDLE: begin
                if (grant_ok && (pick_ifu || pick_lsu)) begin
                    state_d = REQ;
                    owner_d = pick_lsu ? OWN_LSU : OWN_IFU;
                    last_d  = pick_lsu ? OWN_LSU : OWN_IFU;
                    addr_d  = pick_lsu ? lsu_req_addr : ifu_req_addr;
                    wen_d   = pick_lsu && lsu_req_wen;
                    wdata_d = pick_lsu ? lsu_req_wdata : '0;
                    wmask_d = pick_lsu ? lsu_req_wmask : '0;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = RSP;
                    wd_d    = '0;
                end
            end
            RSP: begin
                if (mem_rsp_valid && mem_rsp_ready) begin
                    state_d = IDLE;
                end else if (!mem_rsp_valid) begin
                    if (wd_q == WD_MAX) state_d = ERR;
                    else                wd_d    = wd_q + WD_W'(1);
                end
            end
            default: begin
                if (owner_rsp_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_IFU;
            wd_q    <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: expected responses queued at stimulus time, checked when the owner sees them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
    logic [31:0] ifu_req_addr, ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
    logic [3:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
    logic [3:0]  mem_req_wmask;

    typedef struct packed {
        logic        own;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    logic grant_q[$];
    int   nrun  = 0;
    int   nfail = 0;

    localparam logic [31:0] K = 32'h5A5A_0000;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_rsp_ready = 1'b1;
        lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
        lsu_req_wdata = '0; lsu_req_wmask = '0; lsu_rsp_ready = 1'b1;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
        tick(); tick(); #1;
        nrun++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid} !== 6'b000100) begin
            nfail++;
            $display("FAIL reset_handshakes got %b want 000100",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid});
        end
        nrun++;
        if ({mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen, ifu_rsp_err, lsu_rsp_err, ifu_rsp_data} !== 103'd0) begin
            nfail++;
            $display("FAIL reset_regs addr=%h wdata=%h mask=%b wen=%b errs=%b%b want all 0",
                     mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen, ifu_rsp_err, lsu_rsp_err);
        end
        ifu_req_valid = 1'b1;
        #1;
        nrun++;
        if (ifu_req_ready !== 1'b0) begin
            nfail++;
            $display("FAIL reset_no_grant ifu_req_ready=%b want 0", ifu_req_ready);
        end
        ifu_req_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ifu_single();
        exp_t e;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; mem_req_ready = 1'b1;
        #1;
        nrun++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            nfail++;
            $display("FAIL single_grant ifu/lsu ready=%b want 10", {ifu_req_ready, lsu_req_ready});
        end
        exp_q.push_back('{own: 1'b0, data: 32'h0000_0413, err: 1'b0});
        tick();
        ifu_req_valid = 1'b0;
        #1;
        nrun++;
        if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, ifu_req_ready} !== {1'b1, 32'h8000_0000, 1'b0, 4'b0, 1'b0}) begin
            nfail++;
            $display("FAIL single_memreq valid=%b addr=%h wen=%b mask=%b want 1 80000000 0 0000",
                     mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask);
        end
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0413;
        #1;
        nrun++;
        if ({ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready} !== 3'b101) begin
            nfail++;
            $display("FAIL single_rsp_valid ifu/lsu/mem_rdy=%b want 101", {ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready});
        end
        if (ifu_rsp_valid && ifu_rsp_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nrun++;
            if ({ifu_rsp_data, ifu_rsp_err} !== {e.data, e.err}) begin
                nfail++;
                $display("FAIL single_rsp_data got %h/%b want %h/%b", ifu_rsp_data, ifu_rsp_err, e.data, e.err);
            end
        end
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        nrun++;
        if ({mem_req_valid, mem_rsp_ready, ifu_rsp_valid, exp_q.size() == 0} !== 4'b0101) begin
            nfail++;
            $display("FAIL single_idle req_v/rsp_rdy/ifu_v/q_empty=%b want 0101",
                     {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, exp_q.size() == 0});
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic        pend = 1'b0;
        logic [31:0] pend_addr = '0;
        int          ngrant = 0;
        logic        done = 1'b0;
        logic        eg;
        exp_t        e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_1000;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_2000; lsu_req_wen = 1'b0; lsu_req_wmask = '0;
        grant_q.push_back(1'b1); grant_q.push_back(1'b0); grant_q.push_back(1'b1);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (ngrant == 3 && exp_q.size() == 0) begin
                done = 1'b1;
            end else begin
                mem_req_ready = 1'b1;
                mem_rsp_valid = pend; mem_rsp_data = pend_addr ^ K; mem_rsp_err = 1'b0;
                #1;
                if (ifu_req_ready || lsu_req_ready) begin
                    eg = (grant_q.size() > 0) ? grant_q.pop_front() : 1'bx;
                    nrun++;
                    if ({ifu_req_ready, lsu_req_ready} !== {~eg, eg}) begin
                        nfail++;
                        $display("FAIL rr_grant%0d ifu/lsu ready=%b want %b", ngrant, {ifu_req_ready, lsu_req_ready}, {~eg, eg});
                    end
                    exp_q.push_back('{own: lsu_req_ready, data: (lsu_req_ready ? 32'h0000_2000 : 32'h0000_1000) ^ K, err: 1'b0});
                    ngrant++;
                end
                if ((ifu_rsp_valid && ifu_rsp_ready) || (lsu_rsp_valid && lsu_rsp_ready)) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : '{own: 1'bx, data: 'x, err: 1'bx};
                    nrun++;
                    if ({lsu_rsp_valid, ifu_rsp_valid, lsu_rsp_valid ? lsu_rsp_data : ifu_rsp_data} !== {e.own, ~e.own, e.data}) begin
                        nfail++;
                        $display("FAIL rr_rsp lsu/ifu valid=%b%b data=%h/%h want owner_lsu=%b data=%h",
                                 lsu_rsp_valid, ifu_rsp_valid, lsu_rsp_data, ifu_rsp_data, e.own, e.data);
                    end
                end
                if (mem_rsp_valid && mem_rsp_ready) pend = 1'b0;
                if (mem_req_valid && mem_req_ready) begin
                    pend = 1'b1;
                    pend_addr = mem_req_addr;
                end
                tick();
            end
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_rsp_valid = 1'b0;
        nrun++;
        if (!done || grant_q.size() != 0) begin
            nfail++;
            $display("FAIL rr_complete grants=%0d pending_rsp=%0d want 3 grants 0 pending", ngrant, exp_q.size());
            grant_q.delete(); exp_q.delete();
        end
        tick();
    endtask

    task automatic test_write_stall();
        exp_t e;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0100; lsu_req_wen = 1'b1;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'b0011; mem_req_ready = 1'b0;
        #1;
        nrun++;
        if (lsu_req_ready !== 1'b1) begin
            nfail++;
            $display("FAIL wr_grant lsu_req_ready=%b want 1", lsu_req_ready);
        end
        exp_q.push_back('{own: 1'b1, data: 32'h0, err: 1'b0});
        tick();
        lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wdata = '0; lsu_req_wmask = 4'hF; lsu_req_wen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            nrun++;
            if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_rsp_ready} !==
                {1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b0}) begin
                nfail++;
                $display("FAIL wr_stall%0d v=%b a=%h wen=%b d=%h m=%b rsp_rdy=%b want 1 80000100 1 deadbeef 0011 0",
                         i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_rsp_ready);
            end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0;
        #1;
        nrun++;
        if ({lsu_rsp_valid, ifu_rsp_valid} !== 2'b10) begin
            nfail++;
            $display("FAIL wr_rsp_valid lsu/ifu=%b want 10", {lsu_rsp_valid, ifu_rsp_valid});
        end
        if (lsu_rsp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nrun++;
            if ({lsu_rsp_data, lsu_rsp_err} !== {e.data, e.err}) begin
                nfail++;
                $display("FAIL wr_rsp_data got %h/%b want %h/%b", lsu_rsp_data, lsu_rsp_err, e.data, e.err);
            end
        end
        tick();
        mem_rsp_valid = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        logic early = 1'b0;
        exp_t e;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0200; lsu_req_wen = 1'b0;
        lsu_req_wdata = '0; lsu_req_wmask = '0; mem_req_ready = 1'b0; lsu_rsp_ready = 1'b1;
        #1;
        nrun++;
        if (lsu_req_ready !== 1'b1) begin
            nfail++;
            $display("FAIL to_grant lsu_req_ready=%b want 1", lsu_req_ready);
        end
        exp_q.push_back('{own: 1'b1, data: 32'h0, err: 1'b1});
        tick();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            #1;
            if (lsu_rsp_valid !== 1'b0) early = 1'b1;
            tick();
        end
        nrun++;
        if (early) begin
            nfail++;
            $display("FAIL to_early lsu_rsp_valid seen before cycle 9 want none");
        end
        nrun++;
        if ({lsu_rsp_valid, ifu_rsp_valid, mem_rsp_ready} !== 3'b100) begin
            nfail++;
            $display("FAIL to_err_valid lsu/ifu valid, mem_rsp_ready=%b want 100", {lsu_rsp_valid, ifu_rsp_valid, mem_rsp_ready});
        end
        if (lsu_rsp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nrun++;
            if ({lsu_rsp_data, lsu_rsp_err} !== {e.data, e.err}) begin
                nfail++;
                $display("FAIL to_err_data got %h/%b want %h/%b", lsu_rsp_data, lsu_rsp_err, e.data, e.err);
            end
        end
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0;
        #1;
        nrun++;
        if ({mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid} !== 3'b100) begin
            nfail++;
            $display("FAIL to_late_drop mem_rdy/ifu_v/lsu_v=%b want 100", {mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid});
        end
        tick();
        mem_rsp_valid = 1'b0;
        tick();
    endtask

    task automatic test_rsp_backpressure();
        exp_t e;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0300; mem_req_ready = 1'b0;
        #1;
        nrun++;
        if (ifu_req_ready !== 1'b1) begin
            nfail++;
            $display("FAIL bp_grant ifu_req_ready=%b want 1", ifu_req_ready);
        end
        exp_q.push_back('{own: 1'b0, data: 32'hCAFE_0001, err: 1'b0});
        tick();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_4000; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_0001; ifu_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            nrun++;
            if ({mem_rsp_ready, ifu_rsp_valid, lsu_req_ready, ifu_req_ready} !== 4'b0100) begin
                nfail++;
                $display("FAIL bp_stall%0d mem_rdy/ifu_v/lsu_rdy/ifu_rdy=%b want 0100",
                         i, {mem_rsp_ready, ifu_rsp_valid, lsu_req_ready, ifu_req_ready});
            end
            tick();
        end
        ifu_rsp_ready = 1'b1;
        #1;
        nrun++;
        if ({mem_rsp_ready, ifu_rsp_valid} !== 2'b11) begin
            nfail++;
            $display("FAIL bp_release mem_rdy/ifu_v=%b want 11", {mem_rsp_ready, ifu_rsp_valid});
        end
        if (ifu_rsp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nrun++;
            if ({ifu_rsp_data, ifu_rsp_err} !== {e.data, e.err}) begin
                nfail++;
                $display("FAIL bp_rsp_data got %h/%b want %h/%b", ifu_rsp_data, ifu_rsp_err, e.data, e.err);
            end
        end
        tick();
        lsu_req_valid = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        nrun++;
        if ({ifu_rsp_valid, mem_req_valid, exp_q.size() == 0} !== 3'b001) begin
            nfail++;
            $display("FAIL bp_once ifu_v/req_v/q_empty=%b want 001", {ifu_rsp_valid, mem_req_valid, exp_q.size() == 0});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0400; mem_req_ready = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        nrun++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_addr, ifu_rsp_err} !==
            {6'b000100, 32'h0, 1'b0}) begin
            nfail++;
            $display("FAIL rstmid_state hs=%b addr=%h err=%b want 000100 00000000 0",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid},
                     mem_req_addr, ifu_rsp_err);
        end
        rst = 1'b0;
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_1234;
        #1;
        nrun++;
        if ({mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid} !== 3'b100) begin
            nfail++;
            $display("FAIL rstmid_drain mem_rdy/ifu_v/lsu_v=%b want 100", {mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid});
        end
        tick();
        mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0500;
        exp_q.push_back('{own: 1'b0, data: 32'h0010_0073, err: 1'b0});
        #1;
        nrun++;
        if (ifu_req_ready !== 1'b1) begin
            nfail++;
            $display("FAIL rstmid_grant ifu_req_ready=%b want 1", ifu_req_ready);
        end
        tick();
        ifu_req_valid = 1'b0;
        #1;
        nrun++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_0500}) begin
            nfail++;
            $display("FAIL rstmid_req valid=%b addr=%h want 1 80000500", mem_req_valid, mem_req_addr);
        end
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0010_0073;
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '{own: 1'bx, data: 'x, err: 1'bx};
        nrun++;
        if ({ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err} !== {1'b1, e.data, e.err}) begin
            nfail++;
            $display("FAIL rstmid_rsp valid=%b data=%h err=%b want 1 %h %b", ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err, e.data, e.err);
        end
        tick();
        mem_rsp_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_ifu_single();
        test_round_robin();
        test_write_stall();
        test_timeout();
        test_rsp_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout simulation did not finish within 100000 time units");
        $fatal(1, "simulation time limit");
    end

endmodule
